// File: rtl/can_rx_filter_fifo.sv
// CAN receive path: edge-triggered frame capture, ID acceptance filter and show-ahead frame FIFO.
// Optional build macro RX_FIFO_TIMESTAMP_EN adds a per-frame 16-bit capture timestamp on rd_timestamp.
module can_rx_filter_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          msg_fresh,
    input  logic [28:0]   msg_id,
    input  logic          extended,
    input  logic          rtr,
    input  logic [3:0]    msg_bytes,
    input  logic [63:0]   msg,
    input  logic          filter_en,
    input  logic [28:0]   acc_code,
    input  logic [28:0]   acc_mask,
    input  logic          acc_ext,
    input  logic          acc_ext_mask,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [28:0]   rd_id,
    output logic          rd_extended,
    output logic          rd_rtr,
    output logic [3:0]    rd_bytes,
    output logic [63:0]   rd_data,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          clr_overflow,
    output logic [7:0]    accept_cnt,
    output logic [7:0]    reject_cnt,
`ifdef RX_FIFO_TIMESTAMP_EN
    output logic [15:0]   rd_timestamp,
`endif
    output logic [7:0]    drop_cnt
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic          r_msg_fresh_q;
    logic          r_cap_valid;
    logic [28:0]   r_cap_id;
    logic          r_cap_ext;
    logic          r_cap_rtr;
    logic [3:0]    r_cap_bytes;
    logic [63:0]   r_cap_data;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overflow;
    logic [7:0]    r_accept_cnt;
    logic [7:0]    r_reject_cnt;
    logic [7:0]    r_drop_cnt;

    logic [28:0]   r_mem_id    [DEPTH];
    logic          r_mem_ext   [DEPTH];
    logic          r_mem_rtr   [DEPTH];
    logic [3:0]    r_mem_bytes [DEPTH];
    logic [63:0]   r_mem_data  [DEPTH];

    logic w_cap_edge;
    logic w_hit;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_cap_edge = msg_fresh & ~r_msg_fresh_q;
    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    assign w_pop      = rd_ready & ~w_empty;
    // Masked ID bits must equal the code; the IDE bit is checked only when its own mask is set.
    assign w_hit      = ~filter_en
                      | (((((r_cap_id ^ acc_code) & acc_mask) == '0))
                         & (~acc_ext_mask | (r_cap_ext == acc_ext)));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = r_cap_valid & w_hit & (~w_full | w_pop);
    assign w_drop     = r_cap_valid & w_hit & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg_fresh_q <= 1'b0;
            r_cap_valid   <= 1'b0;
            r_cap_id      <= '0;
            r_cap_ext     <= 1'b0;
            r_cap_rtr     <= 1'b0;
            r_cap_bytes   <= '0;
            r_cap_data    <= '0;
        end else begin
            r_msg_fresh_q <= msg_fresh;
            r_cap_valid   <= w_cap_edge;
            if (w_cap_edge) begin
                r_cap_id    <= msg_id;
                r_cap_ext   <= extended;
                r_cap_rtr   <= rtr;
                r_cap_bytes <= msg_bytes;
                r_cap_data  <= msg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_accept_cnt <= '0;
            r_reject_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + AW'(1);
                r_accept_cnt <= r_accept_cnt + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (r_cap_valid && !w_hit) begin
                r_reject_cnt <= r_reject_cnt + 8'd1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // NOTE: frame slots carry no reset; every read is gated by rd_valid so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wr_ptr]    <= r_cap_id;
            r_mem_ext[r_wr_ptr]   <= r_cap_ext;
            r_mem_rtr[r_wr_ptr]   <= r_cap_rtr;
            r_mem_bytes[r_wr_ptr] <= r_cap_bytes;
            r_mem_data[r_wr_ptr]  <= r_cap_data;
        end
    end

`ifdef RX_FIFO_TIMESTAMP_EN
    logic [15:0] r_ts_cnt;
    logic [15:0] r_cap_ts;
    logic [15:0] r_mem_ts [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt <= '0;
            r_cap_ts <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 16'd1;
            if (w_cap_edge) begin
                r_cap_ts <= r_ts_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ts[r_wr_ptr] <= r_cap_ts;
        end
    end

    assign rd_timestamp = rd_valid ? r_mem_ts[r_rd_ptr] : '0;
`endif

    assign rd_valid    = ~w_empty;
    assign rd_id       = rd_valid ? r_mem_id[r_rd_ptr]    : '0;
    assign rd_extended = rd_valid ? r_mem_ext[r_rd_ptr]   : 1'b0;
    assign rd_rtr      = rd_valid ? r_mem_rtr[r_rd_ptr]   : 1'b0;
    assign rd_bytes    = rd_valid ? r_mem_bytes[r_rd_ptr] : '0;
    assign rd_data     = rd_valid ? r_mem_data[r_rd_ptr]  : '0;
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign accept_cnt  = r_accept_cnt;
    assign reject_cnt  = r_reject_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_can_rx_filter_fifo.sv
// Bench for can_rx_filter_fifo: transaction-level queue model checked every cycle, plus directed literal checks.
module tb_can_rx_filter_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [28:0] id;
        logic        ext;
        logic        rtr;
        logic [3:0]  bytes;
        logic [63:0] data;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          msg_fresh = 1'b0;
    logic [28:0]   msg_id = '0;
    logic          extended = 1'b0;
    logic          rtr = 1'b0;
    logic [3:0]    msg_bytes = '0;
    logic [63:0]   msg = '0;
    logic          filter_en = 1'b0;
    logic [28:0]   acc_code = '0;
    logic [28:0]   acc_mask = '0;
    logic          acc_ext = 1'b0;
    logic          acc_ext_mask = 1'b0;
    logic          rd_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          rd_valid;
    logic [28:0]   rd_id;
    logic          rd_extended;
    logic          rd_rtr;
    logic [3:0]    rd_bytes;
    logic [63:0]   rd_data;
    logic [AW:0]   level;
    logic          overflow;
    logic [7:0]    accept_cnt;
    logic [7:0]    reject_cnt;
    logic [7:0]    drop_cnt;
`ifdef RX_FIFO_TIMESTAMP_EN
    logic [15:0]   rd_timestamp;
`endif

    always #5 clk = ~clk;

    can_rx_filter_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_fresh    (msg_fresh),
        .msg_id       (msg_id),
        .extended     (extended),
        .rtr          (rtr),
        .msg_bytes    (msg_bytes),
        .msg          (msg),
        .filter_en    (filter_en),
        .acc_code     (acc_code),
        .acc_mask     (acc_mask),
        .acc_ext      (acc_ext),
        .acc_ext_mask (acc_ext_mask),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_id        (rd_id),
        .rd_extended  (rd_extended),
        .rd_rtr       (rd_rtr),
        .rd_bytes     (rd_bytes),
        .rd_data      (rd_data),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .accept_cnt   (accept_cnt),
        .reject_cnt   (reject_cnt),
`ifdef RX_FIFO_TIMESTAMP_EN
        .rd_timestamp (rd_timestamp),
`endif
        .drop_cnt     (drop_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: a queue of stored frames plus counters, advanced once per clock edge.
    frame_t     q[$];
    frame_t     req_frame = '0;
    int         req_seq = 0;
    int         m_seen = 0;
    frame_t     m_frame = '0;
    logic       m_stage = 1'b0;
    logic [7:0] m_acc = '0;
    logic [7:0] m_rej = '0;
    logic [7:0] m_drop = '0;
    logic       m_ovf = 1'b0;
    logic       m_pop, m_hit, m_push, m_drop_now;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_acc   = '0;
            m_rej   = '0;
            m_drop  = '0;
            m_ovf   = 1'b0;
            m_stage = 1'b0;
            m_seen  = req_seq;
        end else begin
            m_pop      = rd_ready && (q.size() != 0);
            m_push     = 1'b0;
            m_drop_now = 1'b0;
            if (m_stage) begin
                m_hit = !filter_en
                      || (((m_frame.id & acc_mask) == (acc_code & acc_mask))
                          && (!acc_ext_mask || (m_frame.ext == acc_ext)));
                if (!m_hit) begin
                    m_rej++;
                end else if ((q.size() < DEPTH) || m_pop) begin
                    m_push = 1'b1;
                    m_acc++;
                end else begin
                    m_drop_now = 1'b1;
                    if (m_drop != 8'hFF) m_drop++;
                end
            end
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(m_frame);
            if (m_drop_now)        m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            m_stage = 1'b0;
            if (req_seq != m_seen) begin
                m_seen  = req_seq;
                m_frame = req_frame;
                m_stage = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            frame_t h;
            h = (q.size() != 0) ? q[0] : '0;
            check("cmp rd_valid",    64'(rd_valid),    64'(q.size() != 0));
            check("cmp level",       64'(level),       64'(q.size()));
            check("cmp rd_id",       64'(rd_id),       64'(h.id));
            check("cmp rd_extended", 64'(rd_extended), 64'(h.ext));
            check("cmp rd_rtr",      64'(rd_rtr),      64'(h.rtr));
            check("cmp rd_bytes",    64'(rd_bytes),    64'(h.bytes));
            check("cmp rd_data",     rd_data,          h.data);
            check("cmp overflow",    64'(overflow),    64'(m_ovf));
            check("cmp accept_cnt",  64'(accept_cnt),  64'(m_acc));
            check("cmp reject_cnt",  64'(reject_cnt),  64'(m_rej));
            check("cmp drop_cnt",    64'(drop_cnt),    64'(m_drop));
        end
    end

    function automatic frame_t mk(input int k);
        frame_t f;
        f.id    = 29'((k & 32'h7FF) << 18);
        f.ext   = 1'b0;
        f.rtr   = k[0];
        f.bytes = 4'(k % 9);
        f.data  = {32'hD00D0000 | 32'(k), 32'(k * 3 + 1)};
        return f;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        msg_fresh = 1'b0;
        rd_ready = 1'b0;
        clr_overflow = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Raises msg_fresh for `hold` cycles; optional pop/clear pulses land exactly on the filter edge.
    task automatic send(input frame_t f, input int hold, input bit pop_s2, input bit clr_s2);
        msg_id    = f.id;
        extended  = f.ext;
        rtr       = f.rtr;
        msg_bytes = f.bytes;
        msg       = f.data;
        req_frame = f;
        req_seq++;
        msg_fresh = 1'b1;
        @(posedge clk); #1;
        if (hold <= 1) msg_fresh = 1'b0;
        if (pop_s2) rd_ready = 1'b1;
        if (clr_s2) clr_overflow = 1'b1;
        @(posedge clk); #1;
        if (pop_s2) rd_ready = 1'b0;
        if (clr_s2) clr_overflow = 1'b0;
        for (int i = 2; i < hold; i++) begin
            @(posedge clk); #1;
        end
        if (hold > 1) begin
            msg_fresh = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic pop();
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset rd_valid", 64'(rd_valid), 64'd0);
        check("reset level",    64'(level),    64'd0);
        check("reset rd_id",    64'(rd_id),    64'd0);
        check("reset counters", {40'd0, accept_cnt, reject_cnt, drop_cnt}, 64'd0);

        // Filter disabled: single frame, visible two clocks after the rise.
        f = '{id: 29'h0CCC0000, ext: 1'b0, rtr: 1'b0, bytes: 4'd5, data: 64'h0000000BADC0FFEE};
        send(f, 1, 1'b0, 1'b0);
        check("t1 rd_valid",   64'(rd_valid),   64'd1);
        check("t1 rd_id",      64'(rd_id),      64'h0CCC0000);
        check("t1 rd_bytes",   64'(rd_bytes),   64'd5);
        check("t1 rd_data",    rd_data,         64'h0000000BADC0FFEE);
        check("t1 level",      64'(level),      64'd1);
        check("t1 accept_cnt", 64'(accept_cnt), 64'd1);

        // ID filter on base ID 0x333.
        do_reset();
        filter_en = 1'b1;
        acc_code  = 29'h0CCC0000;
        acc_mask  = 29'h1FFC0000;
        f = '{id: 29'h0CCC0000, ext: 1'b0, rtr: 1'b0, bytes: 4'd2, data: 64'h1111};
        send(f, 1, 1'b0, 1'b0);
        f = '{id: 29'h11540000, ext: 1'b0, rtr: 1'b0, bytes: 4'd3, data: 64'h2222};
        send(f, 1, 1'b0, 1'b0);
        check("t2 level",      64'(level),      64'd1);
        check("t2 rd_id",      64'(rd_id),      64'h0CCC0000);
        check("t2 accept_cnt", 64'(accept_cnt), 64'd1);
        check("t2 reject_cnt", 64'(reject_cnt), 64'd1);

        // IDE-only filter: extended frames only.
        do_reset();
        acc_mask     = '0;
        acc_ext_mask = 1'b1;
        acc_ext      = 1'b1;
        f = '{id: 29'h04000000, ext: 1'b0, rtr: 1'b0, bytes: 4'd1, data: 64'h33};
        send(f, 1, 1'b0, 1'b0);
        f = '{id: 29'h1ABCDEF1, ext: 1'b1, rtr: 1'b1, bytes: 4'd8, data: 64'hFEDCBA9876543210};
        send(f, 1, 1'b0, 1'b0);
        check("t3 level",       64'(level),       64'd1);
        check("t3 rd_id",       64'(rd_id),       64'h1ABCDEF1);
        check("t3 rd_extended", 64'(rd_extended), 64'd1);
        check("t3 reject_cnt",  64'(reject_cnt),  64'd1);

        // Overflow: five frames into four slots.
        do_reset();
        filter_en    = 1'b0;
        acc_ext_mask = 1'b0;
        for (int k = 1; k <= 5; k++) send(mk(k), 1, 1'b0, 1'b0);
        check("t4 level",    64'(level),    64'd4);
        check("t4 overflow", 64'(overflow), 64'd1);
        check("t4 drop_cnt", 64'(drop_cnt), 64'd1);
        check("t4 head id",  64'(rd_id),    64'(mk(1).id));
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        check("t4 overflow cleared", 64'(overflow), 64'd0);

        // Push and pop on the same edge while full.
        send(mk(5), 1, 1'b1, 1'b0);
        check("t5 level",    64'(level),    64'd4);
        check("t5 overflow", 64'(overflow), 64'd0);
        check("t5 drop_cnt", 64'(drop_cnt), 64'd1);
        for (int k = 2; k <= 5; k++) begin
            check("t5 drain id", 64'(rd_id), 64'(mk(k).id));
            pop();
        end
        check("t5 empty", 64'(rd_valid), 64'd0);

        // Long msg_fresh level, then asynchronous reset mid-drain.
        do_reset();
        send(mk(7), 50, 1'b0, 1'b0);
        check("t6 level after hold", 64'(level),      64'd1);
        check("t6 accept after hold", 64'(accept_cnt), 64'd1);
        send(mk(8), 1, 1'b0, 1'b0);
        send(mk(9), 1, 1'b0, 1'b0);
        pop();
        check("t6 level pre-reset", 64'(level), 64'd2);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6 async rd_valid", 64'(rd_valid), 64'd0);
        check("t6 async level",    64'(level),    64'd0);
        check("t6 async counters", {40'd0, accept_cnt, reject_cnt, drop_cnt}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Drop counter saturation; clear coinciding with a drop loses.
        for (int k = 0; k < 4; k++) send(mk(k), 1, 1'b0, 1'b0);
        for (int k = 0; k < 258; k++) send(mk(k + 10), 1, 1'b0, 1'b0);
        send(mk(300), 1, 1'b0, 1'b1);
        check("t7 overflow set wins", 64'(overflow), 64'd1);
        check("t7 drop saturates",    64'(drop_cnt), 64'd255);
        check("t7 head id",           64'(rd_id),    64'(mk(0).id));

        // Accept counter wrap with continuous draining.
        do_reset();
        rd_ready = 1'b1;
        for (int k = 0; k < 256; k++) send(mk(k), 1, 1'b0, 1'b0);
        @(posedge clk); #1;
        rd_ready = 1'b0;
        check("t8 accept wraps", 64'(accept_cnt), 64'd0);
        check("t8 level",        64'(level),      64'd0);
        check("t8 overflow",     64'(overflow),   64'd0);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
